// File: rtl/img_pkg.sv
// Shared image geometry defaults, FSM state encoding and window constants
// for the 3x3 grain-removal filter sequencer.
package img_pkg;
    localparam int IMG_W_DEF  = 224;
    localparam int IMG_H_DEF  = 224;
    localparam int ADDR_W_DEF = 16;
    localparam int WIN_SIZE   = 9;
    localparam int WIN_DIM    = 3;
    localparam int COORD_W    = 8;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        KICK,
        WAIT,
        EMIT,
        FIN
    } state_t;
endpackage

// File: rtl/win_addr_gen.sv
// 3x3 window read generator: nine row-major reads from a latched base pixel,
// with win_load/win_idx trailing each read by one cycle (memory latency).
// No backpressure: once begun, reads issue back to back.
module win_addr_gen
    import img_pkg::*;
#(
    parameter int IMG_W  = IMG_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_begin,
    input  logic [COORD_W-1:0] i_base_x,
    input  logic [COORD_W-1:0] i_base_y,
    output logic               o_mem_rd_en,
    output logic [ADDR_W-1:0]  o_mem_addr,
    output logic               o_win_load,
    output logic [3:0]         o_win_idx,
    output logic               o_last
);
    logic [1:0]         r_dx;
    logic [1:0]         r_dy;
    logic [COORD_W-1:0] r_bx;
    logic [COORD_W-1:0] r_by;
    logic               r_rd_en;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_win_load;
    logic [3:0]         r_win_idx;

    logic [1:0]         w_dx_n;
    logic [1:0]         w_dy_n;
    logic [COORD_W-1:0] w_bx;
    logic [COORD_W-1:0] w_by;
    logic [ADDR_W-1:0]  w_addr;
    logic               w_last;

    assign w_last = r_rd_en && (r_dx == 2'd2) && (r_dy == 2'd2);

    always_comb begin
        w_dx_n = r_dx;
        w_dy_n = r_dy;
        if (i_begin) begin
            w_dx_n = 2'd0;
            w_dy_n = 2'd0;
        end else if (r_dx == 2'd2) begin
            w_dx_n = 2'd0;
            w_dy_n = r_dy + 2'd1;
        end else begin
            w_dx_n = r_dx + 2'd1;
        end
    end

    // The first read of a window must use the incoming base, not the latched one.
    assign w_bx   = i_begin ? i_base_x : r_bx;
    assign w_by   = i_begin ? i_base_y : r_by;
    assign w_addr = (ADDR_W'(w_by) + ADDR_W'(w_dy_n)) * ADDR_W'(IMG_W)
                  + ADDR_W'(w_bx) + ADDR_W'(w_dx_n);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dx       <= 2'd0;
            r_dy       <= 2'd0;
            r_bx       <= '0;
            r_by       <= '0;
            r_rd_en    <= 1'b0;
            r_addr     <= '0;
            r_win_load <= 1'b0;
            r_win_idx  <= 4'd0;
        end else begin
            r_win_load <= r_rd_en;
            if (r_rd_en) begin
                r_win_idx <= {2'b00, r_dy} * 4'd3 + {2'b00, r_dx};
            end
            if (i_begin) begin
                r_bx    <= i_base_x;
                r_by    <= i_base_y;
                r_dx    <= w_dx_n;
                r_dy    <= w_dy_n;
                r_rd_en <= 1'b1;
                r_addr  <= w_addr;
            end else if (r_rd_en) begin
                if (w_last) begin
                    r_rd_en <= 1'b0;
                end else begin
                    r_dx   <= w_dx_n;
                    r_dy   <= w_dy_n;
                    r_addr <= w_addr;
                end
            end
        end
    end

    assign o_mem_rd_en = r_rd_en;
    assign o_mem_addr  = r_addr;
    assign o_win_load  = r_win_load;
    assign o_win_idx   = r_win_idx;
    assign o_last      = w_last;
endmodule

// File: rtl/filter_sequencer.sv
// Frame sequencer: for every valid 3x3 window, fetch, kick the filter core,
// wait for its result and emit one output pixel; done pulses after the frame.
module filter_sequencer
    import img_pkg::*;
#(
    parameter int IMG_W  = IMG_W_DEF,
    parameter int IMG_H  = IMG_H_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rd_data,
    output logic              win_load,
    output logic [3:0]        win_idx,
    output logic [7:0]        win_data,
    output logic              flt_start,
    input  logic              flt_done,
    output logic              out_valid,
    output logic [7:0]        out_x,
    output logic [7:0]        out_y
);
    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(IMG_W - 3);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(IMG_H - 3);

    state_t             r_state;
    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    logic               r_busy;
    logic               r_done;
    logic               r_flt_start;
    logic               r_out_valid;
    logic [COORD_W-1:0] r_out_x;
    logic [COORD_W-1:0] r_out_y;

    logic               w_row_end;
    logic               w_frame_end;
    logic [COORD_W-1:0] w_nx;
    logic [COORD_W-1:0] w_ny;
    logic               w_begin;
    logic               w_fetch_last;

    assign w_row_end   = (r_x == X_LAST);
    assign w_frame_end = w_row_end && (r_y == Y_LAST);

    // Next window origin: (0,0) when leaving IDLE, else the raster successor.
    always_comb begin
        w_nx = '0;
        w_ny = '0;
        if (r_state != IDLE) begin
            w_nx = w_row_end ? '0 : r_x + 1'b1;
            w_ny = w_row_end ? r_y + 1'b1 : r_y;
        end
    end

    assign w_begin = ((r_state == IDLE) && start) || ((r_state == EMIT) && !w_frame_end);

    win_addr_gen #(
        .IMG_W  (IMG_W),
        .ADDR_W (ADDR_W)
    ) u_win_addr_gen (
        .clk         (clk),
        .rst         (rst),
        .i_begin     (w_begin),
        .i_base_x    (w_nx),
        .i_base_y    (w_ny),
        .o_mem_rd_en (mem_rd_en),
        .o_mem_addr  (mem_addr),
        .o_win_load  (win_load),
        .o_win_idx   (win_idx),
        .o_last      (w_fetch_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_x         <= '0;
            r_y         <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_flt_start <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_x     <= '0;
            r_out_y     <= '0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_x     <= w_nx;
                    r_y     <= w_ny;
                    r_busy  <= 1'b1;
                    r_state <= FETCH;
                end
                FETCH: if (w_fetch_last) r_state <= DRAIN;
                DRAIN: begin
                    r_flt_start <= 1'b1;
                    r_state     <= KICK;
                end
                KICK: begin
                    r_flt_start <= 1'b0;
                    r_state     <= WAIT;
                end
                WAIT: if (flt_done) begin
                    r_out_valid <= 1'b1;
                    r_out_x     <= r_x;
                    r_out_y     <= r_y;
                    r_state     <= EMIT;
                end
                EMIT: begin
                    r_out_valid <= 1'b0;
                    if (w_frame_end) begin
                        r_done  <= 1'b1;
                        r_state <= FIN;
                    end else begin
                        r_x     <= w_nx;
                        r_y     <= w_ny;
                        r_state <= FETCH;
                    end
                end
                FIN: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign flt_start = r_flt_start;
    assign out_valid = r_out_valid;
    assign out_x     = r_out_x;
    assign out_y     = r_out_y;
    assign win_data  = mem_rd_data;
endmodule

// File: tb/tb_filter_sequencer.sv
// Directed bench for filter_sequencer on a 5x4 image: window addresses,
// load timing, pixel order, filter wait, start re-pulses and mid-frame reset.
module tb_filter_sequencer;
    localparam int W  = 5;
    localparam int H  = 4;
    localparam int AW = 16;
    localparam int NPIX = (W - 2) * (H - 2);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy, done, mem_rd_en, win_load, flt_start, flt_done, out_valid;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_rd_data, win_data, out_x, out_y;
    logic [3:0]    win_idx;

    filter_sequencer #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .win_load(win_load), .win_idx(win_idx), .win_data(win_data),
        .flt_start(flt_start), .flt_done(flt_done),
        .out_valid(out_valid), .out_x(out_x), .out_y(out_y)
    );

    always #5 clk = ~clk;

    // Memory model: one-cycle read latency, data derived from the address.
    always @(posedge clk) mem_rd_data <= mem_addr[7:0] ^ 8'h5A;

    // Filter core model: tied high, or a one-cycle pulse dly cycles after flt_start.
    bit   tie = 1'b1;
    int   dly = 5;
    int   fcnt = 0;
    logic flt_p = 1'b0;
    assign flt_done = tie ? 1'b1 : flt_p;
    always @(negedge clk) begin
        flt_p = 1'b0;
        if (fcnt > 0) begin
            fcnt--;
            if (fcnt == 0) flt_p = 1'b1;
        end
        if (flt_start === 1'b1) fcnt = dly;
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Event log, sampled 1 time unit after each rising edge.
    int rd_addr[$], rd_cyc[$], ld_idx[$], ld_cyc[$], ld_dat[$];
    int ov_x[$], ov_y[$], ov_cyc[$], done_cyc[$];
    int cyc = 0, fs_cnt = 0, busy_low = 0, max_addr = 0, st_cyc = 0;
    bit frame_on = 1'b0;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (mem_rd_en === 1'b1) begin
            rd_addr.push_back(int'(mem_addr));
            rd_cyc.push_back(cyc);
            if (int'(mem_addr) > max_addr) max_addr = int'(mem_addr);
        end
        if (win_load === 1'b1) begin
            ld_idx.push_back(int'(win_idx));
            ld_cyc.push_back(cyc);
            ld_dat.push_back(int'(win_data));
        end
        if (out_valid === 1'b1) begin
            ov_x.push_back(int'(out_x));
            ov_y.push_back(int'(out_y));
            ov_cyc.push_back(cyc);
        end
        if (done === 1'b1) done_cyc.push_back(cyc);
        if (flt_start === 1'b1) fs_cnt++;
        if (frame_on && busy !== 1'b1) busy_low++;
    end

    task automatic clear_log();
        rd_addr.delete(); rd_cyc.delete(); ld_idx.delete(); ld_cyc.delete(); ld_dat.delete();
        ov_x.delete(); ov_y.delete(); ov_cyc.delete(); done_cyc.delete();
        fs_cnt = 0; busy_low = 0; max_addr = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        st_cyc = cyc;
        frame_on = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cyc.size() == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (done_cyc.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=no_done required=done_within_%0d", budget);
        end
        frame_on = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_rd_en"}, 32'(mem_rd_en), 0);
        chk({tag, "_win_load"}, 32'(win_load), 0);
        chk({tag, "_flt_start"}, 32'(flt_start), 0);
        chk({tag, "_out_valid"}, 32'(out_valid), 0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
        chk({tag, "_win_idx"}, 32'(win_idx), 0);
    endtask

    typedef struct {
        int x;
        int y;
        int addr0;
    } pix_t;

    pix_t ptab[NPIX];
    int   woff[9];
    int   lastwin[9];

    initial begin
        ptab[0] = '{0, 0, 0};
        ptab[1] = '{1, 0, 1};
        ptab[2] = '{2, 0, 2};
        ptab[3] = '{0, 1, 5};
        ptab[4] = '{1, 1, 6};
        ptab[5] = '{2, 1, 7};
        woff    = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
        lastwin = '{7, 8, 9, 12, 13, 14, 17, 18, 19};

        rst = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        chk("reset_out_x", 32'(out_x), 0);
        chk("reset_out_y", 32'(out_y), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Frame 1: filter result ready immediately.
        clear_log();
        tie = 1'b1;
        pulse_start();
        wait_done(400);
        chk("f1_reads", rd_addr.size(), NPIX * 9);
        chk("f1_loads", ld_idx.size(), NPIX * 9);
        chk("f1_first_read_cyc", rd_cyc.size() > 0 ? rd_cyc[0] : -1, st_cyc + 1);
        for (int i = 0; i < NPIX; i++) begin
            for (int k = 0; k < 9; k++) begin
                if (i * 9 + k < rd_addr.size())
                    chk($sformatf("f1_addr_p%0d_k%0d", i, k), rd_addr[i*9+k], ptab[i].addr0 + woff[k]);
            end
        end
        for (int k = 0; k < 9; k++) begin
            if (45 + k < rd_addr.size())
                chk($sformatf("f1_lastwin_k%0d", k), rd_addr[45+k], lastwin[k]);
        end
        for (int j = 0; j < ld_idx.size() && j < rd_cyc.size(); j++) begin
            chk($sformatf("f1_ld_idx_%0d", j), ld_idx[j], j % 9);
            chk($sformatf("f1_ld_cyc_%0d", j), ld_cyc[j], rd_cyc[j] + 1);
            chk($sformatf("f1_ld_dat_%0d", j), ld_dat[j], (rd_addr[j] & 255) ^ 8'h5A);
        end
        chk("f1_out_count", ov_x.size(), NPIX);
        for (int i = 0; i < ov_x.size() && i < NPIX; i++) begin
            chk($sformatf("f1_out_x_%0d", i), ov_x[i], ptab[i].x);
            chk($sformatf("f1_out_y_%0d", i), ov_y[i], ptab[i].y);
            chk($sformatf("f1_out_cyc_%0d", i), ov_cyc[i], st_cyc + 13 * (i + 1));
        end
        chk("f1_done_count", done_cyc.size(), 1);
        if (done_cyc.size() > 0 && ov_cyc.size() > 0)
            chk("f1_done_cyc", done_cyc[0], ov_cyc[ov_cyc.size()-1] + 1);
        chk("f1_max_addr", max_addr, W * H - 1);
        chk("f1_flt_starts", fs_cnt, NPIX);
        chk("f1_busy_low", busy_low, 0);
        chk("f1_busy_after", 32'(busy), 0);

        // Frame 2: delayed filter result and start re-pulses in FETCH and WAIT.
        clear_log();
        tie = 1'b0;
        dly = 5;
        pulse_start();
        fork
            wait_done(600);
            begin
                repeat (3) @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                repeat (10) @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        join
        chk("f2_out_count", ov_x.size(), NPIX);
        for (int i = 0; i < ov_cyc.size() && i < NPIX; i++) begin
            chk($sformatf("f2_out_cyc_%0d", i), ov_cyc[i], st_cyc + 17 * (i + 1));
            chk($sformatf("f2_out_x_%0d", i), ov_x[i], ptab[i].x);
        end
        chk("f2_done_count", done_cyc.size(), 1);
        chk("f2_busy_low", busy_low, 0);
        chk("f2_reads", rd_addr.size(), NPIX * 9);

        // Frame 3: reset during the third EMIT, then a clean restart.
        clear_log();
        tie = 1'b1;
        pulse_start();
        for (int n = 0; n < 200 && ov_x.size() < 3; n++) @(negedge clk);
        chk("f3_reached_emit3", ov_x.size(), 3);
        rst = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        frame_on = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_log();
        repeat (60) @(negedge clk);
        chk("f3_no_done", done_cyc.size(), 0);
        chk("f3_no_reads", rd_addr.size(), 0);
        chk("f3_idle_busy", 32'(busy), 0);
        pulse_start();
        wait_done(400);
        chk("f3_first_addr", rd_addr.size() > 0 ? rd_addr[0] : -1, 0);
        chk("f3_first_x", ov_x.size() > 0 ? ov_x[0] : -1, 0);
        chk("f3_first_y", ov_y.size() > 0 ? ov_y[0] : -1, 0);
        chk("f3_out_count", ov_x.size(), NPIX);
        chk("f3_done_count", done_cyc.size(), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
